alu: RTL and testbench
======================

# alu

Parameterised registered ALU for the datapath: combines two `bits`-wide operands under a 3-bit opcode, with operand bypass and reduction modes. It produces a `bits+1`-wide result, an odd-parity flag and an invalid-operation flag. All outputs update on the clock edge after inputs are sampled.

## Interface
- `bits`, default 4: operand width (≥ 2).
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `A`, in, `bits`: operand A.
- `B`, in, `bits`: operand B.
- `cin`, in, 1: carry-in for add, serial-in for shift.
- `red_op_A`, in, 1: reduction on A for opcodes 000/001.
- `red_op_B`, in, 1: reduction on B for opcodes 000/001.
- `bypass_A`, in, 1: pass A to Out.
- `bypass_B`, in, 1: pass B to Out.
- `opcode`, in, 3: operation select.
- `Out`, out, `bits+1`: registered result.
- `Odd_parity`, out, 1: registered XOR of all bits of the next Out value.
- `Invalid`, out, 1: registered invalid-operation flag.

## Operation
- Invalid condition, in either of these cases:
  - opcode is 110 or 111;
  - `red_op_A` or `red_op_B` is set while opcode is not 000 or 001.
- Out is selected in priority order:
  1. `bypass_A` → zero-extended A.
  2. Else `bypass_B` → zero-extended B.
  3. Else invalid → 0.
  4. Else by opcode.
- Invalid flag is set whenever the invalid condition holds, independent of bypass.
- Opcode results (all zero-extended to `bits+1`):
  - 000 AND: `red_op_A` → &A. Else `red_op_B` → &B. Else A & B.
  - 001 XOR: `red_op_A` → ^A. Else `red_op_B` → ^B. Else A ^ B.
  - 010 ADD: A + B + cin, full `bits+1` result; no overflow is possible.
  - 011 MUL: A * B, truncated to the low `bits+1` bits.
  - 100 SHIFT left: {A, cin}. A[bits-1] lands in the MSB.
  - 101 ROTATE left: {1'b0, A[bits-2:0], A[bits-1]}.
- When both `red_op_A` and `red_op_B` are set on 000/001, A wins.
- Odd_parity is computed from the same next-state Out value and registered alongside it.

## Timing
- Single register stage; latency is 1 cycle. Inputs sampled at rising edge N appear on outputs after edge N.
- No handshake. A new operation is accepted every cycle, with throughput 1/cycle.
- Reset: Out=0, Odd_parity=0, Invalid=0, applied immediately on `rst` assertion regardless of clk.
- The first edge with `rst` low loads the computed values.
- Reset asserted mid-stream discards the in-flight result; no stale value reappears after release.
- Inputs changing between edges have no effect on outputs; there are no combinational paths to outputs.

## Structure
- Package `alu_pkg`:
  - opcode localparams: `OP_AND`=000, `OP_XOR`=001, `OP_ADD`=010, `OP_MUL`=011, `OP_SHL`=100, `OP_ROL`=101;
  - the invalid-opcode range 110/111.
- One natural sub-module, `alu_core`:
  - purely combinational;
  - computes next Out, parity and invalid from the inputs.
- Top `alu` adds the output register and reset.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → Out=00000, Odd_parity=0, Invalid=0 immediately.
- ADD (bits=4): A=1111, B=0001, cin=1, opcode=010 → next edge Out=10001, Odd_parity=0, Invalid=0.
- MUL and reductions:
  - A=0111, B=0011, opcode=011 → Out=10101 (21).
  - opcode=000, red_op_A=1, A=1111 → Out=00001.
  - opcode=001, red_op_B=1, B=0111 → Out=00001, Odd_parity=1.
- Shift/rotate, A=1011:
  - opcode=100, cin=0 → Out=10110.
  - opcode=101 → Out=00111.
- Invalid cases:
  - opcode=110 → Out=00000, Invalid=1.
  - opcode=010 with red_op_A=1 → Out=00000, Invalid=1.
  - opcode=011 with red_op_B=1 → Invalid=1.
- Bypass priority:
  - bypass_A=1, bypass_B=1, A=0101, B=1010, opcode=111 → Out=00101, Invalid=1.
  - bypass_A=0, bypass_B=1 → Out=01010.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU.
//   OP_*          : opcode encodings
//   OP_INV_*      : unused opcode range that flags an invalid operation
//   is_invalid()  : invalid-operation decode shared by the datapath
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_XOR = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL = 3'b100;
    localparam logic [OP_W-1:0] OP_ROL = 3'b101;
    localparam logic [OP_W-1:0] OP_INV_LO = 3'b110;
    localparam logic [OP_W-1:0] OP_INV_HI = 3'b111;

    // Reductions only make sense for AND/XOR; any other opcode with a
    // reduction request is treated as an illegal combination.
    function automatic logic is_invalid(input logic [OP_W-1:0] opcode,
                                        input logic            red_any);
        logic bad_op;
        logic red_ok;
        bad_op = (opcode == OP_INV_LO) || (opcode == OP_INV_HI);
        red_ok = (opcode == OP_AND) || (opcode == OP_XOR);
        return bad_op || (red_any && !red_ok);
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/control/result bundle for the registered ALU.
//   master : drives A, B, cin, red_op_A/B, bypass_A/B, opcode; receives results
//   slave  : the ALU side; receives operands, drives Out, Odd_parity, Invalid
interface alu_if
    import alu_pkg::*;
#(
    parameter int bits = 4
);
    logic [bits-1:0] A;
    logic [bits-1:0] B;
    logic            cin;
    logic            red_op_A;
    logic            red_op_B;
    logic            bypass_A;
    logic            bypass_B;
    logic [OP_W-1:0] opcode;
    logic [bits:0]   Out;
    logic            Odd_parity;
    logic            Invalid;

    modport master (
        output A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B, opcode,
        input  Out, Odd_parity, Invalid
    );

    modport slave (
        input  A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B, opcode,
        output Out, Odd_parity, Invalid
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: combinational datapath of the ALU.
//   Inputs : A, B (bits), cin, red_op_A, red_op_B, bypass_A, bypass_B, opcode
//   Outputs: result (bits+1) = next Out, parity = XOR of result,
//            invalid = invalid-operation flag (independent of bypass)
module alu_core
    import alu_pkg::*;
#(
    parameter int bits = 4
) (
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    input  logic            cin,
    input  logic            red_op_A,
    input  logic            red_op_B,
    input  logic            bypass_A,
    input  logic            bypass_B,
    input  logic [OP_W-1:0] opcode,
    output logic [bits:0]   result,
    output logic            parity,
    output logic            invalid
);

    logic [bits:0] a_ext;
    logic [bits:0] b_ext;
    logic [bits:0] c_ext;

    assign a_ext = {1'b0, A};
    assign b_ext = {1'b0, B};
    assign c_ext = {{bits{1'b0}}, cin};

    always_comb begin
        result  = '0;
        invalid = is_invalid(opcode, red_op_A | red_op_B);

        if (bypass_A) begin
            result = a_ext;
        end else if (bypass_B) begin
            result = b_ext;
        end else if (invalid) begin
            result = '0;
        end else begin
            case (opcode)
                // red_op_A is tested first so it wins when both are set
                OP_AND: begin
                    if (red_op_A)      result = {{bits{1'b0}}, &A};
                    else if (red_op_B) result = {{bits{1'b0}}, &B};
                    else               result = {1'b0, A & B};
                end
                OP_XOR: begin
                    if (red_op_A)      result = {{bits{1'b0}}, ^A};
                    else if (red_op_B) result = {{bits{1'b0}}, ^B};
                    else               result = {1'b0, A ^ B};
                end
                OP_ADD:  result = a_ext + b_ext + c_ext;
                // product kept to bits+1 width, upper bits dropped
                OP_MUL:  result = a_ext * b_ext;
                OP_SHL:  result = {A, cin};
                OP_ROL:  result = {1'b0, A[bits-2:0], A[bits-1]};
                default: result = '0;
            endcase
        end

        parity = ^result;
    end

endmodule

// File: rtl/alu.sv
// alu: registered ALU, one cycle latency, one operation per cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears Out/Odd_parity/Invalid
//   bus : alu_if slave port (operands/controls in, registered results out)
module alu #(
    parameter int bits = 4
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [bits:0] next_out;
    logic          next_parity;
    logic          next_invalid;

    alu_core #(
        .bits (bits)
    ) u_core (
        .A        (bus.A),
        .B        (bus.B),
        .cin      (bus.cin),
        .red_op_A (bus.red_op_A),
        .red_op_B (bus.red_op_B),
        .bypass_A (bus.bypass_A),
        .bypass_B (bus.bypass_B),
        .opcode   (bus.opcode),
        .result   (next_out),
        .parity   (next_parity),
        .invalid  (next_invalid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Out        <= '0;
            bus.Odd_parity <= 1'b0;
            bus.Invalid    <= 1'b0;
        end else begin
            bus.Out        <= next_out;
            bus.Odd_parity <= next_parity;
            bus.Invalid    <= next_invalid;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu (bits = 4).
module tb_alu;

    localparam int BITS = 4;

    typedef struct {
        string         tag;
        logic [BITS:0] out;
        logic          par;
        logic          inv;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_if #(.bits(BITS)) bus ();

    alu #(.bits(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BITS:0] obs, input logic [BITS:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic c, input logic ra, input logic rb,
                         input logic ba, input logic bb, input logic [2:0] op);
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        bus.red_op_A = ra;
        bus.red_op_B = rb;
        bus.bypass_A = ba;
        bus.bypass_B = bb;
        bus.opcode   = op;
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_out"}, bus.Out, e.out);
            chk({e.tag, "_par"}, {{BITS{1'b0}}, bus.Odd_parity}, {{BITS{1'b0}}, e.par});
            chk({e.tag, "_inv"}, {{BITS{1'b0}}, bus.Invalid}, {{BITS{1'b0}}, e.inv});
        end
    endtask

    // One operation per cycle: drive at negedge, expect result after next posedge.
    task automatic step(input string tag,
                        input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input logic c, input logic ra, input logic rb,
                        input logic ba, input logic bb, input logic [2:0] op,
                        input logic [BITS:0] exp_out, input logic exp_inv);
        exp_t e;
        @(negedge clk);
        drive(a, b, c, ra, rb, ba, bb, op);
        e.tag = tag;
        e.out = exp_out;
        e.par = ^exp_out;
        e.inv = exp_inv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        #2;
        chk("reset_out", bus.Out, 5'b00000);
        chk("reset_par", {4'b0, bus.Odd_parity}, 5'b00000);
        chk("reset_inv", {4'b0, bus.Invalid}, 5'b00000);

        @(negedge clk);
        rst = 1'b0;

        //    tag          A        B        cin   rA    rB    bA    bB    op       Out       Inv
        step("add_full",  4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'b10001, 1'b0);

        // async reset mid-cycle clears immediately, no clock edge needed
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out", bus.Out, 5'b00000);
        chk("async_rst_inv", {4'b0, bus.Invalid}, 5'b00000);

        // in-flight op during reset must be discarded
        @(negedge clk);
        drive(4'b0111, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        @(posedge clk);
        #1;
        chk("rst_hold_out", bus.Out, 5'b00000);
        chk("rst_hold_par", {4'b0, bus.Odd_parity}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;

        step("mul_7x3",   4'b0111, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 5'b10101, 1'b0);
        step("mul_trunc", 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 5'b00001, 1'b0);
        step("and_redA",  4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'b00001, 1'b0);
        step("and_both",  4'b1110, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'b00000, 1'b0);
        step("and_plain", 4'b1100, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'b01000, 1'b0);
        step("xor_redB",  4'b0000, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 5'b00001, 1'b0);
        step("xor_plain", 4'b1100, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 5'b00110, 1'b0);
        step("add_zero",  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'b00000, 1'b0);
        step("shl_cin0",  4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'b10110, 1'b0);
        step("shl_cin1",  4'b1011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'b10111, 1'b0);
        step("rol",       4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 5'b00111, 1'b0);

        // inputs changing between edges must not reach the outputs
        #2;
        drive(4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
        #1;
        chk("hold_between_edges", bus.Out, 5'b00111);

        step("inv_op110", 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 5'b00000, 1'b1);
        step("inv_add_rA",4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'b00000, 1'b1);
        step("inv_mul_rB",4'b0111, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 5'b00000, 1'b1);
        step("inv_shl_rA",4'b1011, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 5'b00000, 1'b1);
        step("byp_both",  4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 5'b00101, 1'b1);
        step("byp_B",     4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 5'b01010, 1'b1);
        step("byp_A_ok",  4'b1110, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'b01110, 1'b0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
